// File: rtl/control_unit.sv
// control_unit: multicycle Moore controller for the CPU datapath.
// Every control output is decoded from the state register alone.
// The instruction's opcode and funct only choose the next state.
// Build option CTRL_EXCEPTION_EN adds two trap paths: arithmetic overflow
// and undefined instruction. Without it, overflow is ignored, and an
// undefined instruction returns to FETCH0 with no side effect.
//
// state    | code | meaning
// RESET    |  0   | datapath reset pulse
// FETCH0   |  1   | issue instruction read at PC
// FETCH1   |  2   | memory wait
// FETCH2   |  3   | load IR, PC <= PC+4
// DECODE   |  4   | load A/B, precompute branch target
// R_ADD    |  5   | A+B into ALUOut
// R_SUB    |  6   | A-B into ALUOut
// R_AND    |  7   | A&B into ALUOut
// I_EXEC   |  8   | A+sext imm into ALUOut (addi)
// R_WB     |  9   | write ALUOut to rd
// I_WB     | 10   | write ALUOut to rt
// ADDR     | 11   | A+sext imm effective address
// MEM0     | 12   | load read at ALUOut
// MEM1     | 13   | memory wait, MDR capture
// LW_WB    | 14   | write MDR to rt
// SW       | 15   | store at ALUOut
// BEQ      | 16   | conditional PC load, equal
// BNE      | 17   | conditional PC load, not equal
// J        | 18   | jump
// JAL0     | 19   | link PC into $31
// JAL1     | 20   | jump
// JR       | 21   | PC <= A
// EXC0_OVF | 22   | EPC <= PC-4, read overflow vector
// EXC0_OPC | 23   | EPC <= PC-4, read invalid-opcode vector
// EXC1     | 24   | memory wait
// EXC2     | 25   | PC <= handler address from MDR

module control_unit #(
    parameter logic [7:0] OVF_VEC = 8'd254,
    parameter logic [7:0] OPC_VEC = 8'd253
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Overflow,
    output logic       RstOut,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       EQorNE,
    output logic       MemRead_Write,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegALoad,
    output logic       RegBLoad,
    output logic       ALUOutLoad,
    output logic       EPCWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [2:0] IorD,
    output logic [1:0] RegDst,
    output logic [3:0] MemtoReg,
    output logic [2:0] PCSrc,
    output logic [5:0] state
);

    localparam logic [5:0] RESET    = 6'd0;
    localparam logic [5:0] FETCH0   = 6'd1;
    localparam logic [5:0] FETCH1   = 6'd2;
    localparam logic [5:0] FETCH2   = 6'd3;
    localparam logic [5:0] DECODE   = 6'd4;
    localparam logic [5:0] R_ADD    = 6'd5;
    localparam logic [5:0] R_SUB    = 6'd6;
    localparam logic [5:0] R_AND    = 6'd7;
    localparam logic [5:0] I_EXEC   = 6'd8;
    localparam logic [5:0] R_WB     = 6'd9;
    localparam logic [5:0] I_WB     = 6'd10;
    localparam logic [5:0] ADDR     = 6'd11;
    localparam logic [5:0] MEM0     = 6'd12;
    localparam logic [5:0] MEM1     = 6'd13;
    localparam logic [5:0] LW_WB    = 6'd14;
    localparam logic [5:0] SW       = 6'd15;
    localparam logic [5:0] BEQ      = 6'd16;
    localparam logic [5:0] BNE      = 6'd17;
    localparam logic [5:0] J        = 6'd18;
    localparam logic [5:0] JAL0     = 6'd19;
    localparam logic [5:0] JAL1     = 6'd20;
    localparam logic [5:0] JR       = 6'd21;
    localparam logic [5:0] EXC0_OVF = 6'd22;
    localparam logic [5:0] EXC0_OPC = 6'd23;
    localparam logic [5:0] EXC1     = 6'd24;
    localparam logic [5:0] EXC2     = 6'd25;

    // The two trap vectors are decoded by the datapath from IorD; if they
    // alias, the two handlers cannot be told apart.
    if (OVF_VEC == OPC_VEC) begin : g_vec_alias
        $error("control_unit: OVF_VEC and OPC_VEC must differ");
    end

    logic [5:0] state_q;
    logic [5:0] state_d;
    logic       bad_next;
    logic       ovf_trap;

`ifdef CTRL_EXCEPTION_EN
    assign ovf_trap = Overflow;
    assign bad_next = 1'b1;
`else
    logic unused_overflow;
    assign unused_overflow = Overflow;
    assign ovf_trap = 1'b0;
    assign bad_next = 1'b0;
`endif

    // Next-state selection; an undefined instruction either traps or refetches.
    always_comb begin
        state_d = FETCH0;
        case (state_q)
            RESET:    state_d = FETCH0;
            FETCH0:   state_d = FETCH1;
            FETCH1:   state_d = FETCH2;
            FETCH2:   state_d = DECODE;
            DECODE: begin
                state_d = bad_next ? EXC0_OPC : FETCH0;
                case (opcode)
                    6'h00: begin
                        case (funct)
                            6'h20:   state_d = R_ADD;
                            6'h22:   state_d = R_SUB;
                            6'h24:   state_d = R_AND;
                            6'h08:   state_d = JR;
                            default: state_d = bad_next ? EXC0_OPC : FETCH0;
                        endcase
                    end
                    6'h08:   state_d = I_EXEC;
                    6'h23:   state_d = ADDR;
                    6'h2b:   state_d = ADDR;
                    6'h04:   state_d = BEQ;
                    6'h05:   state_d = BNE;
                    6'h02:   state_d = J;
                    6'h03:   state_d = JAL0;
                    default: state_d = bad_next ? EXC0_OPC : FETCH0;
                endcase
            end
            R_ADD:    state_d = ovf_trap ? EXC0_OVF : R_WB;
            R_SUB:    state_d = ovf_trap ? EXC0_OVF : R_WB;
            R_AND:    state_d = R_WB;
            I_EXEC:   state_d = ovf_trap ? EXC0_OVF : I_WB;
            ADDR:     state_d = (opcode == 6'h2b) ? SW : MEM0;
            MEM0:     state_d = MEM1;
            MEM1:     state_d = LW_WB;
            JAL0:     state_d = JAL1;
            EXC0_OVF: state_d = EXC1;
            EXC0_OPC: state_d = EXC1;
            EXC1:     state_d = EXC2;
            default:  state_d = FETCH0;
        endcase
    end

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RESET;
        else     state_q <= state_d;
    end

    assign state = state_q;

    // Moore output decode; anything not driven in a state stays 0.
    always_comb begin
        RstOut        = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        EQorNE        = 1'b0;
        MemRead_Write = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        RegALoad      = 1'b0;
        RegBLoad      = 1'b0;
        ALUOutLoad    = 1'b0;
        EPCWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 3'b000;
        IorD          = 3'b000;
        RegDst        = 2'b00;
        MemtoReg      = 4'b0000;
        PCSrc         = 3'b000;
        case (state_q)
            RESET:  RstOut = 1'b1;
            FETCH2: begin
                IRWrite = 1'b1; ALUSrcB = 2'b01; ALUOp = 3'b001; PCWrite = 1'b1;
            end
            DECODE: begin
                RegALoad = 1'b1; RegBLoad = 1'b1; ALUOutLoad = 1'b1;
                ALUSrcB = 2'b11; ALUOp = 3'b001;
            end
            R_ADD:  begin ALUSrcA = 1'b1; ALUOutLoad = 1'b1; ALUOp = 3'b001; end
            R_SUB:  begin ALUSrcA = 1'b1; ALUOutLoad = 1'b1; ALUOp = 3'b010; end
            R_AND:  begin ALUSrcA = 1'b1; ALUOutLoad = 1'b1; ALUOp = 3'b011; end
            // addi and the load/store address both add the immediate to A
            I_EXEC, ADDR: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUOp = 3'b001; ALUOutLoad = 1'b1;
            end
            R_WB:   begin RegWrite = 1'b1; RegDst = 2'b01; end
            I_WB:   RegWrite = 1'b1;
            MEM0:   IorD = 3'b001;
            LW_WB:  begin RegWrite = 1'b1; MemtoReg = 4'b0001; end
            SW:     begin IorD = 3'b001; MemRead_Write = 1'b1; end
            BEQ, BNE: begin
                ALUSrcA = 1'b1; ALUOp = 3'b010; PCWriteCond = 1'b1; PCSrc = 3'b001;
                EQorNE = (state_q == BEQ);
            end
            J, JAL1: begin PCSrc = 3'b010; PCWrite = 1'b1; end
            JAL0:   begin RegDst = 2'b10; MemtoReg = 4'b0110; RegWrite = 1'b1; end
            JR:     begin PCSrc = 3'b100; PCWrite = 1'b1; end
`ifdef CTRL_EXCEPTION_EN
            EXC0_OVF, EXC0_OPC: begin
                EPCWrite = 1'b1; ALUSrcB = 2'b01; ALUOp = 3'b010;
                IorD = (state_q == EXC0_OVF) ? 3'b101 : 3'b100;
            end
            EXC2:   begin PCSrc = 3'b011; PCWrite = 1'b1; end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: drives instruction opcodes into control_unit and checks
// the whole control word every cycle against a per-instruction timeline
// model (cycle number within the instruction -> expected strobes).
// Define CTRL_EXCEPTION_EN for both files to check the trap paths.

module tb_control_unit;

    typedef struct packed {
        logic       rst_out, pc_write, pc_write_cond, eq_or_ne, mem_rw, ir_write;
        logic       reg_write, a_load, b_load, aluout_load, epc_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [2:0] iord;
        logic [1:0] reg_dst;
        logic [3:0] mem_to_reg;
        logic [2:0] pc_src;
    } cw_t;

    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ADDI = 3, K_LW = 4, K_SW = 5;
    localparam int K_BEQ = 6, K_BNE = 7, K_J = 8, K_JAL = 9, K_JR = 10, K_BAD = 11;
    localparam logic [5:0] RESET_CODE  = 6'd0;
    localparam logic [5:0] FETCH0_CODE = 6'd1;
`ifdef CTRL_EXCEPTION_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       Overflow = 1'b0;
    logic       RstOut, PCWrite, PCWriteCond, EQorNE, MemRead_Write, IRWrite;
    logic       RegWrite, RegALoad, RegBLoad, ALUOutLoad, EPCWrite, ALUSrcA;
    logic [1:0] ALUSrcB, RegDst;
    logic [2:0] ALUOp, IorD, PCSrc;
    logic [3:0] MemtoReg;
    logic [5:0] state;
    cw_t        obs;

    int total = 0;
    int passed = 0;

    control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .Overflow(Overflow),
        .RstOut(RstOut), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .EQorNE(EQorNE),
        .MemRead_Write(MemRead_Write), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegALoad(RegALoad), .RegBLoad(RegBLoad), .ALUOutLoad(ALUOutLoad),
        .EPCWrite(EPCWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSrc(PCSrc), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {RstOut, PCWrite, PCWriteCond, EQorNE, MemRead_Write, IRWrite,
                  RegWrite, RegALoad, RegBLoad, ALUOutLoad, EPCWrite, ALUSrcA,
                  ALUSrcB, ALUOp, IorD, RegDst, MemtoReg, PCSrc};

    function automatic bit traps_ovf(int k, bit ovf);
        return EXC_EN && ovf && (k == K_ADD || k == K_SUB || k == K_ADDI);
    endfunction

    function automatic int instr_len(int k, bit ovf);
        if (traps_ovf(k, ovf)) return 8;
        case (k)
            K_ADD, K_SUB, K_AND, K_ADDI, K_SW, K_JAL: return 6;
            K_LW:  return 8;
            K_BAD: return EXC_EN ? 7 : 4;
            default: return 5;
        endcase
    endfunction

    // Expected control word in cycle n (1-based) of an instruction of kind k.
    function automatic cw_t exp_word(int k, bit ovf, int n);
        cw_t w;
        bit  t_ovf;
        bit  t_opc;
        int  e;
        w = '0;
        t_ovf = traps_ovf(k, ovf);
        t_opc = EXC_EN && (k == K_BAD);
        e = t_ovf ? 6 : 5;
        if (n == 3) begin
            w.ir_write = 1; w.alu_src_b = 2'b01; w.alu_op = 3'b001; w.pc_write = 1;
        end else if (n == 4) begin
            w.a_load = 1; w.b_load = 1; w.aluout_load = 1; w.alu_src_b = 2'b11; w.alu_op = 3'b001;
        end else if ((t_ovf || t_opc) && n >= e) begin
            if (n == e) begin
                w.epc_write = 1; w.alu_src_b = 2'b01; w.alu_op = 3'b010;
                w.iord = t_ovf ? 3'b101 : 3'b100;
            end else if (n == e + 2) begin
                w.pc_src = 3'b011; w.pc_write = 1;
            end
        end else if (n >= 5) begin
            case (k)
                K_ADD, K_SUB, K_AND: begin
                    if (n == 5) begin
                        w.alu_src_a = 1; w.aluout_load = 1;
                        w.alu_op = (k == K_ADD) ? 3'b001 : (k == K_SUB) ? 3'b010 : 3'b011;
                    end else if (n == 6) begin
                        w.reg_write = 1; w.reg_dst = 2'b01;
                    end
                end
                K_ADDI, K_LW, K_SW: begin
                    if (n == 5) begin
                        w.alu_src_a = 1; w.alu_src_b = 2'b10; w.alu_op = 3'b001; w.aluout_load = 1;
                    end else if (n == 6 && k == K_ADDI) begin
                        w.reg_write = 1;
                    end else if (n == 6) begin
                        w.iord = 3'b001; w.mem_rw = (k == K_SW);
                    end else if (n == 8) begin
                        w.reg_write = 1; w.mem_to_reg = 4'b0001;
                    end
                end
                K_BEQ, K_BNE: begin
                    w.alu_src_a = 1; w.alu_op = 3'b010; w.pc_write_cond = 1;
                    w.eq_or_ne = (k == K_BEQ); w.pc_src = 3'b001;
                end
                K_J, K_JR: begin
                    w.pc_write = 1; w.pc_src = (k == K_J) ? 3'b010 : 3'b100;
                end
                K_JAL: begin
                    if (n == 5) begin
                        w.reg_dst = 2'b10; w.mem_to_reg = 4'b0110; w.reg_write = 1;
                    end else begin
                        w.pc_src = 3'b010; w.pc_write = 1;
                    end
                end
                default: ;
            endcase
        end
        return w;
    endfunction

    // Instruction encoding for a kind; funct is random where it is a don't-care.
    task automatic encode(input int k, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom_range(0, 63));
        case (k)
            K_ADD:  begin op = 6'h00; fn = 6'h20; end
            K_SUB:  begin op = 6'h00; fn = 6'h22; end
            K_AND:  begin op = 6'h00; fn = 6'h24; end
            K_JR:   begin op = 6'h00; fn = 6'h08; end
            K_ADDI: op = 6'h08;
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2b;
            K_BEQ:  op = 6'h04;
            K_BNE:  op = 6'h05;
            K_J:    op = 6'h02;
            K_JAL:  op = 6'h03;
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    op = 6'h00;
                    while (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h08)
                        fn = 6'($urandom_range(0, 63));
                end else begin
                    op = 6'h3f;
                    while (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2b ||
                           op == 6'h04 || op == 6'h05 || op == 6'h02 || op == 6'h03)
                        op = 6'($urandom_range(0, 63));
                end
            end
        endcase
    endtask

    // Runs one instruction from FETCH0; abort_at > 0 asserts rst during that cycle.
    task automatic run_instr(input int k, input bit ovf, input int abort_at);
        logic [5:0] op, fn;
        int len;
        cw_t e;
        encode(k, op, fn);
        opcode = op; funct = fn; Overflow = ovf;
        len = instr_len(k, ovf);
        for (int n = 1; n <= len; n++) begin
            e = exp_word(k, ovf, n);
            total++;
            if (obs !== e)
                $display("FAIL cw kind=%0d op=%h fn=%h ovf=%0d cycle=%0d got=%h expected=%h",
                         k, op, fn, ovf, n, obs, e);
            else passed++;
            if (n == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        total++;
        if (state !== FETCH0_CODE)
            $display("FAIL end_state kind=%0d got=%0d expected=%0d", k, state, FETCH0_CODE);
        else passed++;
    endtask

    task automatic test_reset();
        cw_t rw;
        rw = '0; rw.rst_out = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (obs !== rw || state !== RESET_CODE)
                $display("FAIL reset_hold cycle=%0d got=%h/%0d expected=%h/%0d", i, obs, state, rw, RESET_CODE);
            else passed++;
        end
        rst = 1'b0;
        total++;
        if (obs !== rw) $display("FAIL reset_extra got=%h expected=%h", obs, rw);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (state !== FETCH0_CODE || obs !== '0)
            $display("FAIL reset_exit got=%0d/%h expected=%0d/0", state, obs, FETCH0_CODE);
        else passed++;
    endtask

    task automatic test_directed();
        run_instr(K_ADD, 1'b0, 0);
        run_instr(K_LW, 1'b0, 0);
        run_instr(K_SW, 1'b0, 0);
        run_instr(K_BNE, 1'b0, 0);
        run_instr(K_BEQ, 1'b0, 0);
        run_instr(K_J, 1'b0, 0);
        run_instr(K_JAL, 1'b0, 0);
        run_instr(K_JR, 1'b0, 0);
        run_instr(K_ADD, 1'b1, 0);
        run_instr(K_ADDI, 1'b1, 0);
        run_instr(K_AND, 1'b1, 0);
        run_instr(K_BAD, 1'b0, 0);
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 80; i++)
            run_instr(int'($urandom_range(0, 11)), 1'b1 & $urandom_range(0, 1), 0);
    endtask

    task automatic test_reset_midflight();
        cw_t rw;
        rw = '0; rw.rst_out = 1'b1;
        run_instr(K_LW, 1'b0, 7);
        total++;
        if (state !== RESET_CODE || obs !== rw)
            $display("FAIL midflight_reset got=%0d/%h expected=%0d/%h", state, obs, RESET_CODE, rw);
        else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (state !== FETCH0_CODE || obs.reg_write !== 1'b0)
            $display("FAIL midflight_resume got=%0d/%b expected=%0d/0", state, obs.reg_write, FETCH0_CODE);
        else passed++;
        run_instr(K_LW, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
